// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit fifo-drain block:
//   - state_t       : FSM state encoding (3-bit)
//   - DEFAULT_*     : default bit timing and frame width
//   - baud_cnt_width: width of the per-bit cycle counter for a given bit period
// Optional feature macro: UART_PARITY_EN (adds the ST_PARITY state).
// -----------------------------------------------------------------------------
package uart_pkg;

   // 100 MHz system clock at 115200 baud, 8 data bits per frame.
   localparam int DEFAULT_CLKS_PER_BIT = 868;
   localparam int DEFAULT_DATA_BITS    = 8;

   // Frame sequencer states. ST_PARITY exists only when parity is built in,
   // so a parity-free build carries no dead state.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_LOAD   = 3'd2,
      ST_START  = 3'd3,
      ST_DATA   = 3'd4,
`ifdef UART_PARITY_EN
      ST_PARITY = 3'd5,
`endif
      ST_STOP   = 3'd6
   } state_t;

   // Width needed to count 0..clks_per_bit-1; never narrower than one bit.
   function automatic int baud_cnt_width(input int clks_per_bit);
      return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_fifo_drain_if.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_drain_if
// Read-port bundle between the TX fifo and the UART drain stage.
//   fifo_empty : fifo -> drain, fifo has no words
//   fifo_data  : fifo -> drain, read data, valid the cycle after a pop
//   fifo_rd_en : drain -> fifo, one-cycle pop strobe
// Modports: master = drain side (issues pops), slave = fifo side.
// -----------------------------------------------------------------------------
interface uart_tx_fifo_drain_if #(
   parameter int FIFO_WIDTH = 16
);
   logic                  fifo_empty;
   logic [FIFO_WIDTH-1:0] fifo_data;
   logic                  fifo_rd_en;

   modport master (
      input  fifo_empty,
      input  fifo_data,
      output fifo_rd_en
   );

   modport slave (
      output fifo_empty,
      output fifo_data,
      input  fifo_rd_en
   );

endinterface

// File: rtl/uart_baud_counter.sv
// -----------------------------------------------------------------------------
// uart_baud_counter
// Free-running per-bit cycle counter: counts 0..CLKS_PER_BIT-1 and wraps.
// Ports:
//   clock       in  system clock
//   reset       in  asynchronous active-high reset
//   clear       in  hold the count at zero (used while no bit is on the line)
//   bit_end     out high on the terminal count (last cycle of a bit)
//   bit_pre_end out high on the cycle before the terminal count
// -----------------------------------------------------------------------------
module uart_baud_counter
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   output logic bit_end,
   output logic bit_pre_end
);

   localparam int            CW       = baud_cnt_width(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] PRE_LAST = CW'(CLKS_PER_BIT - 2);

   logic [CW-1:0] count;

   // The count restarts at every bit boundary so each bit lasts exactly
   // CLKS_PER_BIT cycles; clear parks it at zero between frames so the
   // start bit begins from a known phase.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear || bit_end) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   // bit_pre_end lets the sequencer register a strobe that lands exactly on
   // the terminal cycle instead of one cycle late.
   assign bit_end     = (count == LAST);
   assign bit_pre_end = (count == PRE_LAST);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_drain
// UART transmitter that drains the TX fifo: pops one word at a time and sends
// its low DATA_BITS as start(0), data LSB first, [parity], STOP_BITS stop(1).
// Keeps popping for as long as the fifo is not empty.
// Ports:
//   clock    in   system clock, posedge
//   reset    in   asynchronous active-high reset
//   fifo     if   uart_tx_fifo_drain_if.master (fifo_empty, fifo_data, fifo_rd_en)
//   tx       out  serial line, idle high, registered
//   busy     out  high whenever the sequencer is not idle
//   tx_done  out  one-cycle pulse on the last cycle of the final stop bit
// Optional feature macro: UART_PARITY_EN (parity bit between data and stop;
//   even parity, or odd parity when PARITY_ODD=1).
// -----------------------------------------------------------------------------
module uart_tx_fifo_drain
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int DATA_BITS    = DEFAULT_DATA_BITS,
   parameter int FIFO_WIDTH   = 16,
   parameter int STOP_BITS    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic                 clock,
   input  logic                 reset,
   uart_tx_fifo_drain_if.master fifo,
   output logic                 tx,
   output logic                 busy,
   output logic                 tx_done
);

   localparam logic [2:0] LAST_DATA_IDX = 3'(DATA_BITS - 1);
   localparam logic [2:0] LAST_STOP_IDX = 3'(STOP_BITS - 1);

   state_t               state_q, state_d;
   logic                 tx_q, tx_d;
   logic                 rd_en_q, rd_en_d;
   logic                 done_q, done_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [2:0]           idx_q, idx_d;
   logic                 baud_clear;
   logic                 bit_end;
   logic                 bit_pre_end;
`ifdef UART_PARITY_EN
   logic                 parity_q, parity_d;
`endif

   uart_baud_counter #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clock       (clock),
      .reset       (reset),
      .clear       (baud_clear),
      .bit_end     (bit_end),
      .bit_pre_end (bit_pre_end)
   );

   // All outputs except busy come straight from flops so the line and the
   // fifo strobe never glitch. Reset drops the in-flight word: the fifo has
   // already popped it, so it is simply lost rather than re-read.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         tx_q     <= 1'b1;
         rd_en_q  <= 1'b0;
         done_q   <= 1'b0;
         shift_q  <= '0;
         idx_q    <= '0;
`ifdef UART_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         tx_q     <= tx_d;
         rd_en_q  <= rd_en_d;
         done_q   <= done_d;
         shift_q  <= shift_d;
         idx_q    <= idx_d;
`ifdef UART_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   // Next-state and next-output logic. Each branch computes what the line
   // should show during the next cycle, so tx changes exactly on the bit
   // boundary edge. idx_q counts data bits in ST_DATA and stop bits in
   // ST_STOP. fifo_empty is only looked at in ST_IDLE, which is what keeps
   // the block from ever popping an empty fifo mid-frame.
   always_comb begin
      state_d    = state_q;
      tx_d       = tx_q;
      rd_en_d    = 1'b0;
      done_d     = 1'b0;
      shift_d    = shift_q;
      idx_d      = idx_q;
      baud_clear = 1'b0;
`ifdef UART_PARITY_EN
      parity_d   = parity_q;
`endif

      case (state_q)
         ST_IDLE: begin
            tx_d       = 1'b1;
            baud_clear = 1'b1;
            if (!fifo.fifo_empty) begin
               rd_en_d = 1'b1;
               state_d = ST_FETCH;
            end
         end

         ST_FETCH: begin
            baud_clear = 1'b1;
            state_d    = ST_LOAD;
         end

         ST_LOAD: begin
            baud_clear = 1'b1;
            shift_d    = fifo.fifo_data[DATA_BITS-1:0];
            tx_d       = 1'b0;
            idx_d      = '0;
`ifdef UART_PARITY_EN
            parity_d   = (^fifo.fifo_data[DATA_BITS-1:0]) ^ (PARITY_ODD != 0);
`endif
            state_d    = ST_START;
         end

         ST_START: begin
            if (bit_end) begin
               tx_d    = shift_q[0];
               shift_d = shift_q >> 1;
               idx_d   = '0;
               state_d = ST_DATA;
            end
         end

         ST_DATA: begin
            if (bit_end) begin
               if (idx_q == LAST_DATA_IDX) begin
`ifdef UART_PARITY_EN
                  tx_d    = parity_q;
                  state_d = ST_PARITY;
`else
                  tx_d    = 1'b1;
                  idx_d   = '0;
                  state_d = ST_STOP;
`endif
               end else begin
                  tx_d    = shift_q[0];
                  shift_d = shift_q >> 1;
                  idx_d   = idx_q + 1'b1;
               end
            end
         end

`ifdef UART_PARITY_EN
         ST_PARITY: begin
            if (bit_end) begin
               tx_d    = 1'b1;
               idx_d   = '0;
               state_d = ST_STOP;
            end
         end
`endif

         ST_STOP: begin
            if (bit_pre_end && (idx_q == LAST_STOP_IDX)) begin
               done_d = 1'b1;
            end
            if (bit_end) begin
               if (idx_q == LAST_STOP_IDX) begin
                  state_d = ST_IDLE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end

         default: begin
            tx_d    = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
   end

   assign fifo.fifo_rd_en = rd_en_q;
   assign tx              = tx_q;
   assign tx_done         = done_q;
   assign busy            = (state_q != ST_IDLE);

endmodule
